// File: rtl/abr_pkg.sv
// Shared types and parameter derivations for the UART auto-baud detector.
package abr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HI,
    ST_WAIT_FE,
    ST_MEASURE,
    ST_DONE,
    ST_ERR
  } abr_state_e;

  // Bit times covered by the measurement: each falling-edge interval of 0x55 spans two bits.
  function automatic int abr_bits(input int edges);
    return 2 * edges;
  endfunction

  function automatic int abr_shift(input int edges);
    return $clog2(2 * edges);
  endfunction

  function automatic int abr_brg_w(input int cnt_w, input int edges);
    return cnt_w - $clog2(2 * edges);
  endfunction

endpackage

// File: rtl/abr_rx_sync.sv
// Two-flop synchroniser for the UART receive line plus falling-edge detect.
module abr_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fe_o
);

  logic meta_q;
  logic rx_s_q;
  logic rx_dly_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      rx_dly_q <= 1'b1;
    end else begin
      meta_q   <= rx_i;
      rx_s_q   <= meta_q;
      rx_dly_q <= rx_s_q;
    end
  end

  assign rx_s_o = rx_s_q;
  assign fe_o   = rx_dly_q & ~rx_s_q;

endmodule

// File: rtl/abr_detector.sv
// UART auto-baud detector: times the 0x55 sync character and loads the divided result.
// Build option ABR_ROUND_EN selects round-to-nearest division instead of truncation.
module abr_detector
  import abr_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int EDGES = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                abaud_set,
  input  logic                                abaud_clr,
  input  logic                                rx,
  output logic                                abaud,
  output logic [abr_brg_w(CNT_W, EDGES)-1:0]  brg,
  output logic                                brg_vld,
  output logic                                rxif,
  output logic                                abr_err
);

  localparam int BITS  = abr_bits(EDGES);
  localparam int SHIFT = abr_shift(EDGES);
  localparam int BRG_W = abr_brg_w(CNT_W, EDGES);
  localparam logic [3:0]     EDGE_LAST = 4'(EDGES - 1);
  localparam logic [CNT_W:0] HALF      = (CNT_W + 1)'(BITS / 2);

  abr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        edge_q, edge_d;
  logic [BRG_W-1:0]  brg_q, brg_d;
  logic              brg_vld_q, brg_vld_d;
  logic              abr_err_q, abr_err_d;

  logic              rx_s;
  logic              fe;
  logic              last_fe;
  logic [CNT_W:0]    period;
  logic [CNT_W:0]    dividend;
  logic [CNT_W:0]    quot;
  logic [BRG_W-1:0]  brg_new;

  abr_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx),
    .rx_s_o (rx_s),
    .fe_o   (fe)
  );

  // Divider works one bit wider than the counter so the +1 and rounding cannot wrap.
  assign period = {1'b0, cnt_q} + 1'b1;
`ifdef ABR_ROUND_EN
  assign dividend = period + HALF;
`else
  assign dividend = period;
`endif
  assign quot    = dividend >> SHIFT;
  assign brg_new = (|(quot >> BRG_W)) ? {BRG_W{1'b1}} : quot[BRG_W-1:0];
  assign last_fe = fe && (edge_q == EDGE_LAST);

  // NOTE: every next-state signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    brg_d     = brg_q;
    brg_vld_d = brg_vld_q;
    abr_err_d = abr_err_q;
    case (state_q)
      ST_IDLE: begin
        if (abaud_set && !abaud_clr) begin
          state_d   = ST_WAIT_HI;
          abr_err_d = 1'b0;
        end
      end
      ST_WAIT_HI: if (rx_s) state_d = ST_WAIT_FE;
      ST_WAIT_FE: begin
        if (fe) begin
          cnt_d   = '0;
          edge_d  = '0;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        cnt_d = cnt_q + 1'b1;
        if (fe) edge_d = edge_q + 1'b1;
        if (last_fe) begin
          brg_d     = brg_new;
          brg_vld_d = 1'b1;
          state_d   = ST_DONE;
        end else if (&cnt_q) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR: begin
        abr_err_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort discards any result that would have been committed this cycle.
    if (abaud_clr && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      brg_d     = brg_q;
      brg_vld_d = brg_vld_q;
      abr_err_d = abr_err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      brg_q     <= '0;
      brg_vld_q <= 1'b0;
      abr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      brg_q     <= brg_d;
      brg_vld_q <= brg_vld_d;
      abr_err_q <= abr_err_d;
    end
  end

  assign abaud   = (state_q != ST_IDLE);
  assign rxif    = (state_q == ST_DONE);
  assign brg     = brg_q;
  assign brg_vld = brg_vld_q;
  assign abr_err = abr_err_q;

endmodule

// File: tb/tb_abr_detector.sv
// Directed bench for abr_detector: default instance plus an 8-bit-counter instance for overflow.
module tb_abr_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abaud_set = 1'b0;
  logic abaud_clr = 1'b0;
  logic rx = 1'b1;

  logic        abaud, brg_vld, rxif, abr_err;
  logic [12:0] brg;
  logic        abaud8, brg_vld8, rxif8, abr_err8;
  logic [4:0]  brg8;

  int checks = 0;
  int failures = 0;
  int rxif_cnt = 0;
  int rxif8_cnt = 0;

  always #5 clk = ~clk;

  abr_detector dut (
    .clk (clk), .rst_n (rst_n), .abaud_set (abaud_set), .abaud_clr (abaud_clr), .rx (rx),
    .abaud (abaud), .brg (brg), .brg_vld (brg_vld), .rxif (rxif), .abr_err (abr_err)
  );

  abr_detector #(.CNT_W(8), .EDGES(4)) dut8 (
    .clk (clk), .rst_n (rst_n), .abaud_set (abaud_set), .abaud_clr (abaud_clr), .rx (rx),
    .abaud (abaud8), .brg (brg8), .brg_vld (brg_vld8), .rxif (rxif8), .abr_err (abr_err8)
  );

  always @(negedge clk) begin
    if (rxif)  rxif_cnt++;
    if (rxif8) rxif8_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_set();
    abaud_set = 1'b1;
    @(negedge clk);
    abaud_set = 1'b0;
  endtask

  task automatic pulse_clr();
    abaud_clr = 1'b1;
    @(negedge clk);
    abaud_clr = 1'b0;
  endtask

  // 0x55 frame LSB first; bit 7 of the frame is stretched by 'extra' so P = 8*bitlen + extra.
  task automatic send_frame(input int bitlen, input int extra);
    logic [9:0] fr;
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (bitlen + ((i == 7) ? extra : 0)) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (abaud && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, abaud, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int base8;
    int exp132;
`ifdef ABR_ROUND_EN
    exp132 = 17;
`else
    exp132 = 16;
`endif

    repeat (3) @(negedge clk);
    check("rst_abaud", abaud, 0);
    check("rst_brg", brg, 0);
    check("rst_brg_vld", brg_vld, 0);
    check("rst_rxif", rxif, 0);
    check("rst_abr_err", abr_err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal 16 clk/bit: P = 128
    base = rxif_cnt;
    pulse_set();
    check("arm_latency", abaud, 1);
    send_frame(16, 0);
    wait_idle("p128_idle");
    check("p128_brg", brg, 16);
    check("p128_vld", brg_vld, 1);
    check("p128_rxif_once", rxif_cnt - base, 1);
    check("p128_err", abr_err, 0);

    pulse_set();
    send_frame(16, 3);
    wait_idle("p131_idle");
    check("p131_brg", brg, 16);

    pulse_set();
    send_frame(16, 4);
    wait_idle("p132_idle");
    check("p132_brg", brg, exp132);

    // Arm while rx is low mid-character, then 10 clk/bit
    base = rxif_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    pulse_set();
    repeat (25) @(negedge clk);
    check("midchar_armed", abaud, 1);
    check("midchar_no_rxif", rxif_cnt - base, 0);
    check("midchar_brg_held", brg, exp132);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(10, 0);
    wait_idle("p80_idle");
    check("p80_brg", brg, 10);
    check("p80_rxif_once", rxif_cnt - base, 1);

    // Overflow on the 8-bit instance
    base = rxif_cnt;
    base8 = rxif8_cnt;
    pulse_set();
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("ovf_err", abr_err8, 1);
    check("ovf_abaud", abaud8, 0);
    check("ovf_brg_held", brg8, 10);
    check("ovf_no_rxif", rxif8_cnt - base8, 0);
    check("ovf_wide_still_measuring", abaud, 1);
    pulse_clr();
    check("ovf_wide_abort", abaud, 0);
    check("ovf_wide_brg_held", brg, 10);
    check("ovf_wide_no_rxif", rxif_cnt - base, 0);
    pulse_set();
    check("err_cleared_by_set", abr_err8, 0);
    check("rearm8", abaud8, 1);

    // Abort after three falling edges
    base = rxif_cnt;
    for (int k = 0; k < 3; k++) begin
      rx = 1'b0;
      repeat (10) @(negedge clk);
      rx = 1'b1;
      repeat (10) @(negedge clk);
    end
    check("abort_pre_armed", abaud, 1);
    pulse_clr();
    check("abort_idle_next", abaud, 0);
    repeat (20) @(negedge clk);
    check("abort_no_rxif", rxif_cnt - base, 0);
    check("abort_brg_held", brg, 10);
    check("abort_err_held", abr_err8, 0);

    // Simultaneous set and clear stays idle
    abaud_set = 1'b1;
    abaud_clr = 1'b1;
    @(negedge clk);
    abaud_set = 1'b0;
    abaud_clr = 1'b0;
    check("setclr_idle", abaud, 0);
    @(negedge clk);
    check("setclr_idle2", abaud, 0);

    // Asynchronous reset during MEASURE
    pulse_set();
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_measuring", abaud, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_abaud", abaud, 0);
    check("arst_brg", brg, 0);
    check("arst_vld", brg_vld, 0);
    check("arst_rxif", rxif, 0);
    check("arst_err", abr_err, 0);
    @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    base = rxif_cnt;
    pulse_set();
    send_frame(16, 0);
    wait_idle("post_rst_idle");
    check("post_rst_brg", brg, 16);
    check("post_rst_vld", brg_vld, 1);
    check("post_rst_rxif_once", rxif_cnt - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
